// File: rtl/peripheral_bin2bcd_disp.sv
// peripheral_bin2bcd_disp
// Converts a signed 16-bit value to six 4-bit display codes for 7-segment
// decoders: numerals 0..9, 4'hB for a minus sign and 4'hF for a blank.
// Conversion is a sequential double-dabble, one iteration per clock. The
// display register only changes in the FORMAT cycle, so the previous
// result stays visible and intact while a conversion is running.
module peripheral_bin2bcd_disp (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  output logic        busy,
  output logic        done,
  output logic [23:0] digits
);

  typedef enum logic [1:0] {
    IDLE,
    ABS,
    SHIFT,
    FORMAT
  } state_t;

  localparam logic [23:0] DIGITS_RESET = 24'hFFFFF0;
  localparam logic [3:0]  CODE_BLANK   = 4'hF;
  localparam logic [3:0]  CODE_MINUS   = 4'hB;
  localparam logic [3:0]  LAST_ITER    = 4'd15;

  state_t      state;
  logic [15:0] cap_value;
  logic        sign;
  logic [15:0] mag;
  logic [19:0] bcd;
  logic [3:0]  iter;

  logic [19:0] bcd_adj;
  logic [23:0] fmt;
  int          msd;

  // Double-dabble correction: every BCD nibble of 5 or more gets +3 so that
  // the following left shift carries correctly into the next decimal digit.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Display formatting: blank everything above the most-significant nonzero
  // digit (units always shown), then put the minus sign just above it.
  // Five magnitude digits at most, so the sign always fits in d5.
  always_comb begin
    fmt = {6{CODE_BLANK}};
    msd = 0;
    for (int i = 1; i < 5; i++) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        msd = i;
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (i <= msd) begin
        fmt[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    if (sign) begin
      fmt[4*(msd+1) +: 4] = CODE_MINUS;
    end
  end

  // Control FSM with registered busy/done/digits outputs; a load is only
  // honoured in IDLE, so requests during a conversion are simply dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cap_value <= 16'd0;
      sign      <= 1'b0;
      mag       <= 16'd0;
      bcd       <= 20'd0;
      iter      <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      digits    <= DIGITS_RESET;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            cap_value <= value;
            busy      <= 1'b1;
            state     <= ABS;
          end
        end
        ABS: begin
          // -32768 maps to 16'h8000, which is 32768 as an unsigned magnitude
          sign  <= cap_value[15];
          mag   <= cap_value[15] ? (~cap_value + 16'd1) : cap_value;
          bcd   <= 20'd0;
          iter  <= 4'd0;
          state <= SHIFT;
        end
        SHIFT: begin
          {bcd, mag} <= {bcd_adj, mag} << 1;
          iter       <= iter + 4'd1;
          if (iter == LAST_ITER) begin
            state <= FORMAT;
          end
        end
        FORMAT: begin
          digits <= fmt;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_bin2bcd_disp.sv
// tb_peripheral_bin2bcd_disp
// Directed bench for the signed binary to display-code converter: a table of
// values with hand-computed display codes, plus hand-written sequences for
// load-while-busy, reset mid-conversion and a continuously held load.
module tb_peripheral_bin2bcd_disp;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic        busy;
  logic        done;
  logic [23:0] digits;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [15:0] v;
    logic [23:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[12];

  peripheral_bin2bcd_disp dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .value  (value),
    .busy   (busy),
    .done   (done),
    .digits (digits)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something upstream never terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One comparison; counted, and reported only when it does not match
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Full conversion: load at edge N, watch the display hold its old value,
  // expect done exactly 18 edges later with the new codes, then done drop.
  task automatic applyStimulus(input logic [15:0] v, input logic [23:0] prev,
                               input logic [23:0] exp, input string name);
    int   cycles;
    logic torn;
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    value = ~v;
    checkOutput({name, " busy_after_load"}, {31'b0, busy}, 32'd1);
    cycles = 0;
    torn   = 1'b0;
    while (!done && cycles < 40) begin
      if (digits !== prev) torn = 1'b1;
      tick();
      cycles++;
    end
    checkOutput({name, " hold_prev"}, {31'b0, torn}, 32'd0);
    checkOutput({name, " latency"}, 32'(cycles), 32'd18);
    checkOutput({name, " digits"}, {8'b0, digits}, {8'b0, exp});
    checkOutput({name, " busy_in_done"}, {31'b0, busy}, 32'd0);
    tick();
    checkOutput({name, " done_one_cycle"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    logic [23:0] prev;
    int          dones;
    logic        exp_done;

    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{16'd1234, 24'hFF1234, "v1234"};
    vecs[1]  = '{16'hFFD6, 24'hFFFB42, "vneg42"};
    vecs[2]  = '{16'h8000, 24'hB32768, "vneg32768"};
    vecs[3]  = '{16'h7FFF, 24'hF32767, "v32767"};
    vecs[4]  = '{16'd0,    24'hFFFFF0, "v0"};
    vecs[5]  = '{16'd5,    24'hFFFFF5, "v5"};
    vecs[6]  = '{16'hFFFF, 24'hFFFFB1, "vneg1"};
    vecs[7]  = '{16'd1000, 24'hFF1000, "v1000"};
    vecs[8]  = '{16'd10000, 24'hF10000, "v10000"};
    vecs[9]  = '{16'hD8F1, 24'hFB9999, "vneg9999"};
    vecs[10] = '{16'hD8F0, 24'hB10000, "vneg10000"};
    vecs[11] = '{16'd90,   24'hFFFF90, "v90"};

    reset = 1'b1;
    load  = 1'b0;
    value = 16'd0;
    #22;
    checkOutput("reset_digits", {8'b0, digits}, {8'b0, 24'hFFFFF0});
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();
    checkOutput("idle_digits", {8'b0, digits}, {8'b0, 24'hFFFFF0});
    checkOutput("idle_busy", {31'b0, busy}, 32'd0);
    checkOutput("idle_done", {31'b0, done}, 32'd0);

    prev = 24'hFFFFF0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].v, prev, vecs[i].exp, vecs[i].name);
      prev = vecs[i].exp;
    end

    $display("[TB] load while busy is ignored");
    value = 16'd100;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    value = 16'd999;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dones++;
    end
    checkOutput("busy_load done_count", 32'(dones), 32'd1);
    checkOutput("busy_load digits", {8'b0, digits}, {8'b0, 24'hFFF100});
    checkOutput("busy_load idle", {31'b0, busy}, 32'd0);

    $display("[TB] reset mid-conversion");
    value = 16'd555;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    reset = 1'b1;
    #1;
    checkOutput("abort digits", {8'b0, digits}, {8'b0, 24'hFFFFF0});
    checkOutput("abort busy", {31'b0, busy}, 32'd0);
    checkOutput("abort done", {31'b0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) dones++;
    end
    checkOutput("abort no_done", 32'(dones), 32'd0);
    checkOutput("abort digits_after", {8'b0, digits}, {8'b0, 24'hFFFFF0});
    applyStimulus(16'd7, 24'hFFFFF0, 24'hFFFFF7, "after_abort_v7");

    $display("[TB] held load restarts every 19 cycles");
    value = 16'hFFFB;
    load  = 1'b1;
    tick();
    checkOutput("held busy_start", {31'b0, busy}, 32'd1);
    for (int k = 1; k <= 56; k++) begin
      tick();
      exp_done = ((k % 19) == 18);
      checkOutput($sformatf("held done k=%0d", k), {31'b0, done}, {31'b0, exp_done});
      checkOutput($sformatf("held busy k=%0d", k), {31'b0, busy}, {31'b0, ~exp_done});
      if (exp_done) begin
        checkOutput($sformatf("held digits k=%0d", k), {8'b0, digits}, {8'b0, 24'hFFFFB5});
      end
    end
    load = 1'b0;
    tick();
    tick();
    checkOutput("held stop idle", {31'b0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
